spi_reg_bridge: RTL and testbench

//  SPI slave front-end of the PWM peripheral. Runs SPI mode 0, MSB first.

---
 rtl/spi_bridge_pkg.sv | 7 +
 rtl/spi_reg_bridge_if.sv | 13 +
 rtl/spi_pin_sync.sv | 40 ++++
 rtl/spi_reg_bridge.sv | 111 +++++++++++
 tb/tb_spi_reg_bridge.sv | 172 +++++++++++++++++
 5 files changed

// File: rtl/spi_bridge_pkg.sv
// spi_bridge_pkg: shared state type and frame layout constants for the SPI register bridge
package spi_bridge_pkg;
    typedef enum logic [2:0] {IDLE, CMD, RD_ISSUE, DATA, DONE} state_t;
    localparam int CMD_RW_BIT   = 7;
    localparam int CMD_ADDR_LSB = 0;
    localparam int BYTE_BITS    = 8;
endpackage

// File: rtl/spi_reg_bridge_if.sv
// spi_reg_bridge_if: register bus between the SPI bridge (master) and the register file (slave)
interface spi_reg_bridge_if #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 8
);
    logic              read;
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data_write;
    logic [DATA_W-1:0] data_read;
    modport master (output read, write, addr, data_write, input data_read);
    modport slave  (input read, write, addr, data_write, output data_read);
endinterface

// File: rtl/spi_pin_sync.sv
// spi_pin_sync: synchronises sclk/cs_n/mosi into clk and flags sclk and cs_n edges
module spi_pin_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sclk,
    input  logic cs_n,
    input  logic mosi,
    output logic sclk_rise,
    output logic sclk_fall,
    output logic cs_fall,
    output logic cs_rise,
    output logic mosi_s
);
    logic [SYNC_STAGES-1:0] sclk_sh, cs_sh, mosi_sh;
    logic sclk_d, cs_d, sclk_s, cs_s;
    assign sclk_s    = sclk_sh[SYNC_STAGES-1];
    assign cs_s      = cs_sh[SYNC_STAGES-1];
    assign mosi_s    = mosi_sh[SYNC_STAGES-1];
    assign sclk_rise = ~cs_s & sclk_s & ~sclk_d;
    assign sclk_fall = ~cs_s & ~sclk_s & sclk_d;
    assign cs_fall   = ~cs_s & cs_d;
    assign cs_rise   = cs_s & ~cs_d;
    // Synchroniser chains; cs_n starts low so a released-high pin only produces a harmless rise while idle
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            sclk_sh <= '0;
            cs_sh   <= '0;
            mosi_sh <= '0;
            sclk_d  <= 1'b0;
            cs_d    <= 1'b0;
        end else begin
            sclk_sh <= {sclk_sh[SYNC_STAGES-2:0], sclk};
            cs_sh   <= {cs_sh[SYNC_STAGES-2:0], cs_n};
            mosi_sh <= {mosi_sh[SYNC_STAGES-2:0], mosi};
            sclk_d  <= sclk_s;
            cs_d    <= cs_s;
        end
endmodule

// File: rtl/spi_reg_bridge.sv
// spi_reg_bridge: SPI mode-0 slave turning {rw,rsvd,addr} + data frames into register bus strobes.
// Build option SPI_BURST_AUTOINC_EN: further data bytes in a frame go to auto-incremented addresses.
module spi_reg_bridge
    import spi_bridge_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int ADDR_W      = 6,
    parameter int DATA_W      = BYTE_BITS
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sclk,
    input  logic              cs_n,
    input  logic              mosi,
    output logic              miso,
    output logic              frame_err,
    spi_reg_bridge_if.master  bus
);
    localparam int CW = $clog2(DATA_W);
    state_t state;
    logic [CW-1:0] bit_cnt;
    logic [DATA_W-1:0] shift_in, shift_out, next_byte;
    logic rw, got_data, last_bit;
    logic sclk_rise, sclk_fall, cs_fall, cs_rise, mosi_s;
    spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk(clk), .rst_n(rst_n), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
        .sclk_rise(sclk_rise), .sclk_fall(sclk_fall), .cs_fall(cs_fall),
        .cs_rise(cs_rise), .mosi_s(mosi_s)
    );
    assign next_byte = {shift_in[DATA_W-2:0], mosi_s};
    assign last_bit  = bit_cnt == CW'(DATA_W - 1);
    // Frame FSM: shifts bits in on sclk rise, out on sclk fall, and issues one-cycle bus strobes
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state          <= IDLE;
            bit_cnt        <= '0;
            shift_in       <= '0;
            shift_out      <= '0;
            rw             <= 1'b0;
            got_data       <= 1'b0;
            miso           <= 1'b0;
            frame_err      <= 1'b0;
            bus.read       <= 1'b0;
            bus.write      <= 1'b0;
            bus.addr       <= '0;
            bus.data_write <= '0;
        end else begin
            bus.read  <= 1'b0;
            bus.write <= 1'b0;
            frame_err <= 1'b0;
            if (cs_rise) begin
                frame_err <= (bit_cnt != '0) || (state == DATA && rw && !got_data);
                state     <= IDLE;
                bit_cnt   <= '0;
                miso      <= 1'b0;
            end else begin
                case (state)
                    IDLE: if (cs_fall) begin
                        state    <= CMD;
                        bit_cnt  <= '0;
                        got_data <= 1'b0;
                    end
                    CMD: if (sclk_rise) begin
                        shift_in <= next_byte;
                        bit_cnt  <= last_bit ? '0 : bit_cnt + CW'(1);
                        if (last_bit) begin
                            bus.addr <= next_byte[CMD_ADDR_LSB +: ADDR_W];
                            rw       <= next_byte[CMD_RW_BIT];
                            bus.read <= !next_byte[CMD_RW_BIT];
                            state    <= next_byte[CMD_RW_BIT] ? DATA : RD_ISSUE;
                        end
                    end
                    RD_ISSUE: begin
                        shift_out <= bus.data_read;
                        state     <= DATA;
                    end
                    DATA: begin
                        if (sclk_fall && !rw) begin
                            miso      <= shift_out[DATA_W-1];
                            shift_out <= shift_out << 1;
                        end
                        if (sclk_rise) begin
                            shift_in <= next_byte;
                            bit_cnt  <= last_bit ? '0 : bit_cnt + CW'(1);
                            got_data <= 1'b1;
`ifdef SPI_BURST_AUTOINC_EN
                            if (rw && got_data && bit_cnt == '0)
                                bus.addr <= bus.addr + ADDR_W'(1);
`endif
                            if (last_bit) begin
                                bus.write <= rw;
                                if (rw)
                                    bus.data_write <= next_byte;
`ifdef SPI_BURST_AUTOINC_EN
                                if (!rw) begin
                                    bus.addr <= bus.addr + ADDR_W'(1);
                                    bus.read <= 1'b1;
                                    state    <= RD_ISSUE;
                                end
`else
                                miso  <= 1'b0;
                                state <= DONE;
`endif
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
endmodule

// File: tb/tb_spi_reg_bridge.sv
// tb_spi_reg_bridge: random and directed SPI frames checked against a frame-level model of the bridge
module tb_spi_reg_bridge;
    logic clk = 1'b0, rst_n = 1'b0, sclk = 1'b0, cs_n = 1'b1, mosi = 1'b0;
    logic miso, frame_err;
    logic [7:0] mem [64];
    logic [7:0] tx_q[$], rx_q[$];
    logic [13:0] wr_log[$];
    logic [5:0] rd_log[$];
    int err_cnt = 0, viol = 0, miso_idle = 0, total = 0, bad = 0;
    logic idle_watch = 1'b0, rd_d = 1'b0, wr_d = 1'b0, er_d = 1'b0;
`ifdef SPI_BURST_AUTOINC_EN
    localparam bit BURST = 1'b1;
`else
    localparam bit BURST = 1'b0;
`endif

    spi_reg_bridge_if #(.ADDR_W(6), .DATA_W(8)) bus ();
    assign bus.data_read = mem[bus.addr];

    spi_reg_bridge dut (
        .clk(clk), .rst_n(rst_n), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
        .miso(miso), .frame_err(frame_err), .bus(bus)
    );

    always #5 clk = ~clk;

    // Bus monitor: logs strobes and counts overlapping or stretched pulses
    always @(negedge clk) begin
        if (bus.write) wr_log.push_back({bus.addr, bus.data_write});
        if (bus.read) rd_log.push_back(bus.addr);
        if (frame_err) err_cnt++;
        if ((bus.read && bus.write) || (bus.read && rd_d) || (bus.write && wr_d) || (frame_err && er_d)) viol++;
        if (idle_watch && miso) miso_idle++;
        rd_d = bus.read;
        wr_d = bus.write;
        er_d = frame_err;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic spi_bit(input logic b, output logic s);
        mosi = b;
        wait_clk(4);
        s = miso;
        sclk = 1'b1;
        wait_clk(4);
        sclk = 1'b0;
    endtask

    task automatic load(input logic [31:0] w, input int n);
        tx_q.delete();
        for (int i = n - 1; i >= 0; i--) tx_q.push_back(w[i*8 +: 8]);
    endtask

    // Sends n full bytes plus 'partial' bits of tx_q[n], then checks strobes, errors and miso bytes
    task automatic run_frame(input int n, input int partial);
        int wb, rb, eb, d, n_wr, n_rd;
        logic [7:0] cmd, r, e;
        logic s, is_wr, is_rd, exp_err;
        wb = wr_log.size();
        rb = rd_log.size();
        eb = err_cnt;
        rx_q.delete();
        cs_n = 1'b0;
        wait_clk(4);
        for (int i = 0; i < n; i++) begin
            for (int k = 7; k >= 0; k--) begin
                spi_bit(tx_q[i][k], s);
                r[k] = s;
            end
            rx_q.push_back(r);
        end
        for (int k = 7; k > 7 - partial; k--) spi_bit(tx_q[n][k], s);
        wait_clk(4);
        cs_n = 1'b1;
        wait_clk(8);
        cmd = n > 0 ? tx_q[0] : 8'h00;
        d = n > 0 ? n - 1 : 0;
        is_wr = n > 0 && cmd[7];
        is_rd = n > 0 && !cmd[7];
        exp_err = (partial != 0 && !(!BURST && n >= 2)) || (is_wr && d == 0 && partial == 0);
        n_wr = is_wr ? (BURST ? d : (d > 0 ? 1 : 0)) : 0;
        n_rd = is_rd ? (BURST ? d + 1 : 1) : 0;
        check("frame_err_pulses", err_cnt - eb, 32'(exp_err));
        check("write_count", wr_log.size() - wb, n_wr);
        for (int i = 0; i < n_wr && wb + i < wr_log.size(); i++)
            check("write_addr_data", wr_log[wb + i], {6'(cmd[5:0] + i), tx_q[1 + i]});
        check("read_count", rd_log.size() - rb, n_rd);
        for (int i = 0; i < n_rd && rb + i < rd_log.size(); i++)
            check("read_addr", rd_log[rb + i], 6'(cmd[5:0] + i));
        for (int j = 0; j < n; j++) begin
            e = (is_rd && j >= 1 && (BURST || j == 1)) ? mem[6'(cmd[5:0] + j - 1)] : 8'h00;
            check("miso_byte", rx_q[j], e);
        end
    endtask

    initial begin
        int eb, wb, rb, n, partial;
        logic s;
        foreach (mem[i]) mem[i] = 8'($urandom);
        wait_clk(3);
        check("reset_read", bus.read, 0);
        check("reset_write", bus.write, 0);
        check("reset_frame_err", frame_err, 0);
        check("reset_miso", miso, 0);
        check("reset_addr", bus.addr, 0);
        check("reset_data_write", bus.data_write, 0);
        rst_n = 1'b1;
        wait_clk(4);
        load(32'h8134, 2);
        run_frame(2, 0);
        check("t1_addr_hold", bus.addr, 6'h01);
        check("t1_data_hold", bus.data_write, 8'h34);
        mem[10] = 8'h5C;
        load(32'h0A00, 2);
        run_frame(2, 0);
        load(32'h85A7, 2);
        run_frame(1, 5);
        load(32'hBF112233, 4);
        run_frame(4, 0);
        cs_n = 1'b0;
        wait_clk(4);
        for (int k = 7; k >= 5; k--) spi_bit(k[0], s);
        rst_n = 1'b0;
        #1;
        check("midreset_outputs", {bus.read, bus.write, frame_err, miso, bus.addr, bus.data_write}, 0);
        wait_clk(2);
        rst_n = 1'b1;
        eb = err_cnt;
        wb = wr_log.size();
        rb = rd_log.size();
        for (int k = 4; k >= 0; k--) spi_bit(k[0], s);
        wait_clk(4);
        cs_n = 1'b1;
        wait_clk(8);
        check("midreset_no_strobe", (wr_log.size() - wb) + (rd_log.size() - rb), 0);
        check("midreset_no_err", err_cnt - eb, 0);
        load(32'hC59E, 2);
        run_frame(2, 0);
        eb = err_cnt;
        wb = wr_log.size();
        rb = rd_log.size();
        idle_watch = 1'b1;
        for (int k = 0; k < 16; k++) spi_bit(1'($urandom), s);
        wait_clk(8);
        idle_watch = 1'b0;
        check("idle_sclk_no_strobe", (wr_log.size() - wb) + (rd_log.size() - rb), 0);
        check("idle_sclk_no_err", err_cnt - eb, 0);
        check("idle_sclk_miso_low", miso_idle, 0);
        for (int t = 0; t < 30; t++) begin
            foreach (mem[i]) mem[i] = 8'($urandom);
            n = $urandom_range(0, 4);
            partial = (n == 0 || $urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0;
            tx_q.delete();
            for (int i = 0; i <= n; i++) tx_q.push_back(8'($urandom));
            run_frame(n, partial);
        end
        check("strobe_exclusive_single_cycle", viol, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
